// File: rtl/apb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_arb_pkg
// Purpose  : Shared widths, FSM state type and the PSELx slave decode for the
//            multi-requester APB master.
// Revision : 1.0 - initial release
// ============================================================================
package apb_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    // APB transfer phases
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // PADDR[15:14] selects one of four slaves on the segment (slave 0 = wrapper)
    function automatic logic [3:0] psel_decode(input logic [1:0] sel);
        logic [3:0] onehot;
        case (sel)
            2'b00:   onehot = 4'b0001;
            2'b01:   onehot = 4'b0010;
            2'b10:   onehot = 4'b0100;
            default: onehot = 4'b1000;
        endcase
        return onehot;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_arb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb_rr_arbiter
// Purpose  : Combinational round-robin pick. Searches from last_grant+1
//            (wrapping) for the first active request. The pointer register
//            lives in the parent so it only moves on an actual accept.
// Revision : 1.0 - initial release
// ============================================================================
module apb_rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    input  logic               enable_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o
);

    logic [IDX_W-1:0] idx;
    logic             found;

    // Rotating priority search; the requester just served ends up lowest.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        idx         = '0;
        found       = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((int'(last_grant_i) + k) % NUM_REQ);
            if (enable_i && !found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_arb_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_arb_master
// Purpose  : Round-robin arbitrated APB master. Each accepted command runs
//            SETUP then ACCESS; ACCESS ends on PREADY or after TIMEOUT cycles
//            without it, and a one-cycle response goes back to the owner.
// Revision : 1.0 - initial release
// ============================================================================
module apb_arb_master
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [3:0]                PSELx,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic                      PREADY,
    input  logic [DATA_W-1:0]         PRDATA
);

    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      last_grant_q, last_grant_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]     paddr_q, paddr_d;
    logic [DATA_W-1:0]     pwdata_q, pwdata_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  arb_en;
    logic [NUM_REQ-1:0]    grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_any;
    logic [ADDR_W-1:0]     addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]     wdata_arr [NUM_REQ];

    // Split the packed command buses into per-requester lanes.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Grants are only offered when the bus is free or freeing up this cycle;
    // a timed-out ACCESS (no PREADY) returns to IDLE before granting again.
    assign arb_en = !PRESET &&
                    ((state_q == IDLE) || ((state_q == ACCESS) && PREADY));

    apb_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .enable_i     (arb_en),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx)
    );

    assign grant_any = |grant;
    assign req_ready = grant;

    // Next-state, command capture, timeout counting and response generation.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        rsp_valid_d  = '0;
        rsp_rdata_d  = '0;
        rsp_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    // last_grant_q still names the owner of this transfer
                    rsp_valid_d[last_grant_q] = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    state_d     = grant_any ? SETUP : IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_valid_d[last_grant_q] = 1'b1;
                    rsp_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A grant always launches a fresh SETUP with the winner's command.
        if (grant_any) begin
            last_grant_d = grant_idx;
            pwrite_d     = req_write[grant_idx];
            paddr_d      = addr_arr[grant_idx];
            pwdata_d     = wdata_arr[grant_idx];
            cnt_d        = '0;
        end
    end

    // State and datapath registers; reset makes requester 0 the first pick.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q      <= IDLE;
            last_grant_q <= LAST_RST;
            cnt_q        <= '0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign PSELx     = ((state_q == SETUP) || (state_q == ACCESS)) ?
                       psel_decode(paddr_q[ADDR_W-1 -: 2]) : 4'b0000;
    assign PENABLE   = (state_q == ACCESS);
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_arb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_arb_master
// Purpose  : Randomised bench for apb_arb_master. Requester queues and a
//            transfer-level slave model predict grants, APB signalling and
//            responses; a separate monitor checks responses from a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_arb_master;

    localparam int NUM_REQ  = 3;
    localparam int TIMEOUT  = 16;
    localparam int P_IDLE   = 0;
    localparam int P_SETUP  = 1;
    localparam int P_ACCESS = 2;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          wait_n;
    } cmd_t;

    typedef struct {
        int          req;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic                    PCLK = 1'b0;
    logic                    PRESET = 1'b1;
    logic [NUM_REQ-1:0]      req_valid = '0;
    logic [NUM_REQ-1:0]      req_write = '0;
    logic [NUM_REQ*16-1:0]   req_addr  = '0;
    logic [NUM_REQ*32-1:0]   req_wdata = '0;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic [31:0]             rsp_rdata;
    logic                    rsp_err;
    logic [3:0]              PSELx;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [15:0]             PADDR;
    logic [31:0]             PWDATA;
    logic                    PREADY = 1'b0;
    logic [31:0]             PRDATA = '0;

    cmd_t rq [NUM_REQ][$];
    exp_t exp_q [$];
    cmd_t cur;
    int   m_phase = P_IDLE;
    int   m_acc   = 0;
    int   m_last  = NUM_REQ - 1;
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;

    apb_arb_master #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSELx     (PSELx),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [3:0] exp_sel(input logic [15:0] a);
        logic [3:0] one;
        one = 4'b0001;
        return one << a[15:14];
    endfunction

    function automatic int rr_pick();
        for (int k = 1; k <= NUM_REQ; k++) begin
            int i;
            i = (m_last + k) % NUM_REQ;
            if (rq[i].size() > 0) return i;
        end
        return -1;
    endfunction

    function automatic bit busy_any();
        bit b;
        b = (m_phase != P_IDLE) || (exp_q.size() != 0);
        for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) b = 1'b1;
        return b;
    endfunction

    task automatic push_cmd(input int r, input logic wr, input logic [15:0] a,
                            input logic [31:0] wd, input logic [31:0] rd, input int w);
        cmd_t c;
        c.wr = wr; c.addr = a; c.wdata = wd; c.rdata = rd; c.wait_n = w;
        rq[r].push_back(c);
    endtask

    // One clock cycle: drive requesters and slave, check APB and grant.
    task automatic tick(input bit rst);
        logic               ready;
        logic               done_to;
        int                 exp_g;
        int                 g;
        logic [NUM_REQ-1:0] exp_rdy;
        exp_t               e;
        @(negedge PCLK);
        cyc++;
        PRESET = rst;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rq[i].size() > 0) begin
                req_valid[i]            = 1'b1;
                req_write[i]            = rq[i][0].wr;
                req_addr[i*16 +: 16]    = rq[i][0].addr;
                req_wdata[i*32 +: 32]   = rq[i][0].wdata;
            end else begin
                req_valid[i]            = 1'b0;
                req_write[i]            = 1'($urandom);
                req_addr[i*16 +: 16]    = 16'($urandom);
                req_wdata[i*32 +: 32]   = $urandom;
            end
        end
        ready   = 1'b0;
        done_to = 1'b0;
        if (m_phase == P_IDLE) begin
            chk("idle_psel", 32'(PSELx), 32'd0);
            chk("idle_penable", 32'(PENABLE), 32'd0);
        end else begin
            if (m_phase == P_ACCESS) m_acc++;
            chk("psel", 32'(PSELx), 32'(exp_sel(cur.addr)));
            chk("penable", 32'(PENABLE), 32'(m_phase == P_ACCESS));
            chk("paddr", 32'(PADDR), 32'(cur.addr));
            chk("pwrite", 32'(PWRITE), 32'(cur.wr));
            chk("pwdata", PWDATA, cur.wdata);
            if (m_phase == P_ACCESS) begin
                ready   = (cur.wait_n < TIMEOUT) && (m_acc == cur.wait_n + 1);
                done_to = !ready && (m_acc == TIMEOUT);
            end
        end
        PREADY = (m_phase == P_ACCESS) ? ready : 1'($urandom);
        PRDATA = ready ? cur.rdata : $urandom;
        #1;
        exp_g = -1;
        if (!rst && ((m_phase == P_IDLE) || ready)) exp_g = rr_pick();
        exp_rdy = (exp_g >= 0) ? (NUM_REQ'(1) << exp_g) : '0;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (rst) begin
            m_phase = P_IDLE;
            m_acc   = 0;
            m_last  = NUM_REQ - 1;
            exp_q.delete();
        end else begin
            g = -1;
            if (req_ready == exp_rdy) g = exp_g;
            else if ($onehot(req_ready))
                for (int i = 0; i < NUM_REQ; i++)
                    if (req_ready[i] && rq[i].size() > 0) g = i;
            if (ready || done_to) m_phase = P_IDLE;
            else if (m_phase == P_SETUP) m_phase = P_ACCESS;
            if (g >= 0) begin
                cur     = rq[g].pop_front();
                e.req   = g;
                e.err   = (cur.wait_n >= TIMEOUT);
                e.rdata = (e.err || cur.wr) ? 32'd0 : cur.rdata;
                e.cyc   = e.err ? (cyc + 2 + TIMEOUT) : (cyc + 3 + cur.wait_n);
                exp_q.push_back(e);
                m_last  = g;
                m_phase = P_SETUP;
                m_acc   = 0;
            end
        end
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (busy_any() && n < limit) begin
            tick(1'b0);
            n++;
        end
        chk("drain_done", 32'(busy_any()), 32'd0);
    endtask

    function automatic int rand_wait();
        int r;
        r = $urandom_range(0, 15);
        if (r < 10)  return r % 3;
        if (r < 12)  return TIMEOUT - 1;
        if (r == 12) return TIMEOUT;
        return 0;
    endfunction

    // Response monitor: pops the scoreboard whenever a completion appears.
    initial begin
        exp_t e;
        forever begin
            @(negedge PCLK);
            #2;
            if (rsp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 32'd1 << e.req);
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                    if (e.err) begin
                        chk("to_psel", 32'(PSELx), 32'd0);
                        chk("to_penable", 32'(PENABLE), 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // reset then idle
        repeat (3) tick(1'b1);
        chk("rst_psel", 32'(PSELx), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_pwrite", 32'(PWRITE), 32'd0);
        chk("rst_paddr", 32'(PADDR), 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        repeat (2) tick(1'b0);

        // single zero-wait read on requester 0
        push_cmd(0, 1'b0, 16'h0010, $urandom, 32'hDEADBEEF, 0);
        drain(40);

        // write with three wait states to slave 3
        push_cmd(1, 1'b1, 16'hC004, 32'h12345678, $urandom, 3);
        drain(40);

        // two requesters contending for four commands each
        for (int i = 0; i < 4; i++) begin
            push_cmd(0, 1'($urandom), 16'($urandom), $urandom, $urandom, 0);
            push_cmd(1, 1'($urandom), 16'($urandom), $urandom, $urandom, 0);
        end
        drain(100);

        // timeout, then ready on the last allowed cycle
        push_cmd(0, 1'b0, 16'h4000, $urandom, 32'hA5A5A5A5, TIMEOUT);
        drain(60);
        push_cmd(0, 1'b0, 16'h4000, $urandom, 32'h5A5A5A5A, TIMEOUT - 1);
        drain(60);

        // reset during the second ACCESS cycle with other requests pending
        push_cmd(0, 1'b0, 16'h8000, $urandom, $urandom, 5);
        n = 0;
        while (!(m_phase == P_ACCESS && m_acc == 1) && n < 20) begin
            tick(1'b0);
            n++;
        end
        push_cmd(1, 1'b1, 16'h4444, $urandom, $urandom, 0);
        push_cmd(0, 1'b0, 16'h0008, $urandom, $urandom, 0);
        tick(1'b1);
        drain(100);

        // randomised traffic
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (rq[i].size() < 3 && $urandom_range(0, 5) == 0)
                    push_cmd(i, 1'($urandom), 16'($urandom), $urandom, $urandom, rand_wait());
            tick(1'b0);
        end
        drain(3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_arb_master.md
Name: apb_arb_master

Overview:
- Multi-requester APB master: round-robin arbitration among NUM_REQ local command ports, each command sequenced through APB IDLE/SETUP/ACCESS.
- Decodes PADDR[15:14] into one-hot PSELx[3:0] for the four-slave APB segment (slave 0 = APB wrapper).
- Bounds each ACCESS phase with a PREADY timeout and returns read data or an error to the winning requester.

Parameters:
- NUM_REQ, 2, number of requester ports (2..8)
- TIMEOUT, 16, maximum ACCESS cycles without PREADY before abort (>=1)

Ports:
- PCLK  in  1  single clock for the whole block
- PRESET  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester command valid; held until req_ready
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*16  packed addresses, requester i at [16i+15:16i]
- req_wdata  in  NUM_REQ*32  packed write data
- req_ready  out  NUM_REQ  one-hot accept pulse (combinational)
- rsp_valid  out  NUM_REQ  one-hot completion pulse (registered)
- rsp_rdata  out  32  read data, valid with rsp_valid
- rsp_err  out  1  timeout flag, valid with rsp_valid
- PSELx  out  4  one-hot slave select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  16  APB address
- PWDATA  out  32  APB write data
- PREADY  in  1  slave ready
- PRDATA  in  32  slave read data

Behaviour:
- Clocking/reset: one clock PCLK; reset PRESET is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; timeout counter 0; round-robin pointer selects requester 0 as highest priority.
- FSM states and transitions:
  - IDLE -> SETUP when any req_valid.
  - SETUP -> ACCESS unconditionally after 1 cycle.
  - ACCESS -> SETUP on completion if any req_valid in that cycle.
  - ACCESS -> IDLE on completion with no req_valid, or on timeout.
- Arbitration: in IDLE, or in the completing ACCESS cycle, pick the first req_valid at or after (last_grant+1) mod NUM_REQ.
  - Assert req_ready[g] in that same cycle.
  - Latch write, addr and wdata into PWRITE/PADDR/PWDATA at the edge.
  - Update last_grant to g.
- Other grants: no req_ready outside those cycles. Requests arriving in SETUP or non-final ACCESS wait.
- SETUP cycle: PSELx = decode(PADDR[15:14]), where 00->0001, 01->0010, 10->0100, 11->1000; PENABLE=0.
- ACCESS cycles:
  - PSELx held, PENABLE=1.
  - PADDR/PWDATA/PWRITE stable for the whole transfer.
  - Counter increments each ACCESS cycle without PREADY.
- Completion: ACCESS cycle with PREADY=1. Next edge:
  - rsp_valid[g]=1 for one cycle, rsp_err=0.
  - rsp_rdata = PRDATA for reads, 0 for writes.
- Timeout: TIMEOUT-th ACCESS cycle with PREADY=0. Next edge:
  - rsp_valid[g]=1, rsp_err=1, rsp_rdata=0.
  - PSELx=0, PENABLE=0, state IDLE.
  - No grant in the timeout cycle.
  - PREADY=1 in the TIMEOUT-th cycle counts as normal completion.
- Latency (zero-wait slave): accept at T, SETUP T+1, ACCESS T+2, rsp_valid T+3. Back-to-back transfers start SETUP at T+3 with no idle cycle.
- IDLE outputs: PSELx=0, PENABLE=0; PADDR/PWDATA/PWRITE hold their last values.
- Reset mid-transfer: next edge forces the reset state. No rsp_valid is issued for the aborted command, and the command is not replayed.
- Counter clears on entry to SETUP. Counter width is $clog2(TIMEOUT+1).

Decomposition:
- Package apb_arb_pkg:
  - ADDR_W=16, DATA_W=32
  - state enum {IDLE, SETUP, ACCESS}
  - function psel_decode(logic [1:0]) returning logic [3:0]
- Sub-module apb_rr_arbiter:
  - parameter NUM_REQ
  - inputs req, last_grant, enable
  - outputs one-hot grant and grant index
  - purely combinational, with the pointer register held in the parent

Test Plan:
- Reset then idle: PRESET=1 for 3 cycles, no requests -> all outputs 0, PSELx=0000, no req_ready.
- Single read, zero-wait: req0 read addr 0x0010, PREADY=1 in ACCESS, PRDATA=0xDEADBEEF -> PSELx=0001 SETUP T+1, PENABLE T+2, rsp_valid[0] T+3, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Wait states and decode: req1 write addr 0xC004 data 0x12345678, PREADY low 3 ACCESS cycles -> PSELx=1000, PADDR/PWDATA stable 5 cycles, rsp_valid[1], rsp_rdata=0.
- Round-robin fairness: req0 and req1 held valid for 4 commands each -> grants alternate 0,1,0,1..., back-to-back SETUP with no IDLE cycle between transfers.
- Timeout: TIMEOUT=16, addr 0x4000, PREADY held 0 -> 16 ACCESS cycles, rsp_valid with rsp_err=1, rsp_rdata=0, PSELx=0 next cycle; PREADY=1 exactly on cycle 16 -> rsp_err=0.
- Reset mid-ACCESS: PRESET=1 during second ACCESS cycle -> next edge PSELx=0, PENABLE=0, no rsp_valid; after release a pending req0 is granted first.
